// File: rtl/step_controller.sv
// Run/single-step controller driving the clock divider's reset input.
// Conditions run_sw/step_btn and releases div_rst for whole processor-clock periods only.
module step_controller #(
  parameter int STEP_LEN   = 4,
  parameter int DEB_CYCLES = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_sw,
  input  logic             step_btn,
  input  logic             halt_req,
  output logic             div_rst,
  output logic             running,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] step_cnt
);

  localparam int PH_W  = (STEP_LEN > 1) ? $clog2(STEP_LEN) : 1;
  localparam int DEB_W = $clog2(DEB_CYCLES + 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(STEP_LEN - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    STEP  = 2'd3
  } state_t;

  state_t            state, state_next;
  logic              run_meta, run_s;
  logic              step_meta, step_s;
  logic [DEB_W-1:0]  deb_cnt;
  logic              deb_level, deb_prev;
  logic              step_pulse;
  logic [PH_W-1:0]   phase;
  logic              phase_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_meta  <= 1'b0;
      run_s     <= 1'b0;
      step_meta <= 1'b0;
      step_s    <= 1'b0;
    end else begin
      run_meta  <= run_sw;
      run_s     <= run_meta;
      step_meta <= step_btn;
      step_s    <= step_meta;
    end
  end

  // The counter only runs while step_s differs from the accepted level, so any
  // toggle of the synced button (toward or away from it) restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt   <= '0;
      deb_level <= 1'b0;
      deb_prev  <= 1'b0;
    end else begin
      deb_prev <= deb_level;
      if (step_s == deb_level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        deb_cnt   <= '0;
        deb_level <= step_s;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  assign step_pulse = deb_level & ~deb_prev;
  assign phase_last = (phase == PH_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted <= 1'b0;
    end else if (halt_req) begin
      halted <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      div_rst <= 1'b1;
    end else begin
      state   <= state_next;
      div_rst <= (state_next == IDLE);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (!halted) begin
          if (run_s) begin
            state_next = RUN;
          end else if (step_pulse) begin
            state_next = STEP;
          end
        end
      end
      RUN: begin
        if (!run_s || halt_req || halted) begin
          state_next = phase_last ? IDLE : DRAIN;
        end
      end
      DRAIN, STEP: begin
        if (phase_last) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
    end else if (state == IDLE && state_next != IDLE) begin
      phase <= '0;
    end else if (!div_rst) begin
      phase <= phase_last ? '0 : phase + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt <= '0;
    end else if (!div_rst && phase_last) begin
      step_cnt <= step_cnt + 1'b1;
    end
  end

  assign running = (state == RUN) || (state == DRAIN);
  assign busy    = ~div_rst;

endmodule

// File: tb/tb_step_controller.sv
// Bench for step_controller: a window monitor pops expected div_rst low windows
// from a scoreboard queue filled by the scenario tasks.
module tb_step_controller;

  localparam int STEP_LEN = 4;
  localparam int DEB      = 8;
  localparam int CNT_W    = 4;

  logic             clk      = 1'b0;
  logic             rst_n    = 1'b1;
  logic             run_sw   = 1'b0;
  logic             step_btn = 1'b0;
  logic             halt_req = 1'b0;
  logic             div_rst, running, busy, halted;
  logic [CNT_W-1:0] step_cnt;

  typedef struct {
    int lo;
    int hi;
  } win_t;

  win_t sb[$];
  int   checks    = 0;
  int   errors    = 0;
  int   low_len   = 0;
  int   model_cnt = 0;

  step_controller #(
    .STEP_LEN  (STEP_LEN),
    .DEB_CYCLES(DEB),
    .CNT_W     (CNT_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .run_sw  (run_sw),
    .step_btn(step_btn),
    .halt_req(halt_req),
    .div_rst (div_rst),
    .running (running),
    .busy    (busy),
    .halted  (halted),
    .step_cnt(step_cnt)
  );

  always #5 clk = ~clk;

  // Window monitor: measures each div_rst low window and checks it against the queue.
  always @(negedge clk) begin : monitor
    win_t e;
    if (!rst_n) begin
      low_len = 0;
    end else begin
      checks++;
      if (busy !== ~div_rst) begin
        errors++;
        $display("FAIL busy_vs_div_rst: busy=%b required %b", busy, ~div_rst);
      end
      if (div_rst === 1'b0) begin
        low_len++;
      end else if (low_len > 0) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_window: got low window of %0d cycles, required none", low_len);
        end else begin
          e = sb.pop_front();
          if (low_len < e.lo || low_len > e.hi || (low_len % STEP_LEN) != 0) begin
            errors++;
            $display("FAIL window_len: got %0d cycles, required multiple of %0d in [%0d,%0d]",
                     low_len, STEP_LEN, e.lo, e.hi);
          end
        end
        model_cnt = (model_cnt + low_len / STEP_LEN) % (1 << CNT_W);
        checks++;
        if (step_cnt !== CNT_W'(model_cnt)) begin
          errors++;
          $display("FAIL step_cnt_after_window: got %0d, required %0d", step_cnt, model_cnt);
        end
        low_len = 0;
      end
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    sb.delete();
    model_cnt = 0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic press_step(input int hold);
    @(negedge clk);
    step_btn = 1'b1;
    repeat (hold) @(negedge clk);
    step_btn = 1'b0;
    repeat (14) @(negedge clk);
  endtask

  task automatic wait_done(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0 && div_rst === 1'b1) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout: %0d expected windows still pending, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    #1;
    run_sw   = 1'b1;
    step_btn = 1'b1;
    rst_n    = 1'b0;
    repeat (10) begin
      @(negedge clk);
      checks++;
      if ({div_rst, busy, running, halted} !== 4'b1000 || step_cnt !== '0) begin
        errors++;
        $display("FAIL reset_hold: div_rst/busy/running/halted=%b%b%b%b step_cnt=%0d, required 1000 and 0",
                 div_rst, busy, running, halted, step_cnt);
      end
    end
    run_sw   = 1'b0;
    step_btn = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    checks++;
    if (div_rst !== 1'b1 || step_cnt !== '0) begin
      errors++;
      $display("FAIL reset_idle: div_rst=%b step_cnt=%0d, required 1 and 0", div_rst, step_cnt);
    end
  endtask

  task automatic test_wrap();
    for (int n = 0; n < 16; n++) begin
      sb.push_back('{lo: 4, hi: 4});
      press_step(12);
      wait_done("wrap_step", 60);
    end
    checks++;
    if (step_cnt !== '0) begin
      errors++;
      $display("FAIL step_cnt_wrap: got %0d, required 0", step_cnt);
    end
  endtask

  task automatic test_bounce();
    sb.push_back('{lo: 4, hi: 4});
    @(negedge clk);
    for (int t = 0; t < 5; t++) begin
      step_btn = ~step_btn;
      #6;
    end
    repeat (30) @(negedge clk);
    step_btn = 1'b0;
    repeat (15) @(negedge clk);
    wait_done("bounce", 40);
    repeat (20) @(negedge clk);
  endtask

  task automatic test_run_stop();
    sb.push_back('{lo: 40, hi: 48});
    @(negedge clk);
    run_sw = 1'b1;
    repeat (41) @(negedge clk);
    run_sw = 1'b0;
    wait_done("run_stop", 40);
    checks++;
    if (running !== 1'b0 || div_rst !== 1'b1) begin
      errors++;
      $display("FAIL run_stop_idle: running=%b div_rst=%b, required 0 and 1", running, div_rst);
    end
  endtask

  task automatic test_ignore_step();
    sb.push_back('{lo: 4, hi: 400});
    @(negedge clk);
    run_sw = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (running !== 1'b1) begin
      errors++;
      $display("FAIL run_started: running=%b, required 1", running);
    end
    step_btn = 1'b1;
    repeat (15) @(negedge clk);
    step_btn = 1'b0;
    repeat (15) @(negedge clk);
    run_sw = 1'b0;
    wait_done("ignore_step", 40);
    repeat (30) @(negedge clk);
  endtask

  task automatic test_halt();
    bit seen;
    int bad;
    sb.push_back('{lo: 4, hi: 4});
    @(negedge clk);
    run_sw = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (div_rst === 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL halt_run_start: div_rst=%b, required 0 within 20 cycles", div_rst);
    end
    @(negedge clk);
    halt_req = 1'b1;
    @(negedge clk);
    halt_req = 1'b0;
    checks++;
    if (running !== 1'b1 || div_rst !== 1'b0) begin
      errors++;
      $display("FAIL halt_drain: running=%b div_rst=%b, required 1 and 0", running, div_rst);
    end
    wait_done("halt", 20);
    checks++;
    if (halted !== 1'b1 || running !== 1'b0) begin
      errors++;
      $display("FAIL halt_sticky: halted=%b running=%b, required 1 and 0", halted, running);
    end
    bad = 0;
    @(negedge clk);
    step_btn = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (i == 15) step_btn = 1'b0;
      @(negedge clk);
      if (div_rst !== 1'b1) bad++;
    end
    run_sw = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL halt_frozen: div_rst low on %0d cycles, required 0", bad);
    end
  endtask

  task automatic test_async_reset();
    bit seen;
    apply_reset();
    @(negedge clk);
    step_btn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (div_rst === 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL async_step_start: div_rst=%b, required 0 within 30 cycles", div_rst);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (div_rst !== 1'b1 || busy !== 1'b0 || running !== 1'b0 || step_cnt !== '0) begin
      errors++;
      $display("FAIL async_reset_now: div_rst=%b busy=%b running=%b step_cnt=%0d, required 1 0 0 0",
               div_rst, busy, running, step_cnt);
    end
    step_btn = 1'b0;
    repeat (3) @(negedge clk);
    sb.delete();
    model_cnt = 0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    sb.push_back('{lo: 4, hi: 4});
    press_step(12);
    wait_done("async_after", 60);
    checks++;
    if (step_cnt !== CNT_W'(1)) begin
      errors++;
      $display("FAIL async_step_cnt: got %0d, required 1", step_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_bounce();
    test_run_stop();
    test_ignore_step();
    test_halt();
    test_async_reset();
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
